// File: rtl/gb_pkg.sv
// Shared types and address map for the memory-port arbiter slice.
// PPU mode / DMA state enums, region bounds, DMA trigger register.
package gb_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_READ  = 2'd2,
    DMA_WRITE = 2'd3
  } dma_state_t;

  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] VRAM_END     = 16'h9FFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_END      = 16'hFE9F;
  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          DMA_LEN_DEF  = 160;

  function automatic logic in_rng(
    input logic [15:0] a,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: alternates read of src+idx and write of FE00+idx.
// Ports: start/start_page (FF46 write), mem_rdata in; rd/wr/addr/wdata strobes, active out.
module oam_dma_engine
  import gb_pkg::*;
#(
  parameter int DMA_LEN = DMA_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_page,
  input  logic [7:0]  mem_rdata,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_wdata,
  output logic        active
);

  localparam logic [7:0] LAST = 8'(DMA_LEN - 1);

  dma_state_t  state, state_nx;
  logic [15:0] src;
  logic [7:0]  idx;
  logic        last;

  assign last   = (idx == LAST);
  assign active = (state != DMA_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DMA_IDLE;
      src   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        src <= {start_page, 8'h00};
        idx <= '0;
      end else if (state == DMA_WRITE) begin
        idx <= last ? 8'd0 : idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    dma_rd    = 1'b0;
    dma_wr    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    unique case (state)
      DMA_IDLE: begin
        state_nx = DMA_IDLE;
      end
      DMA_START: begin
        state_nx = DMA_READ;
      end
      DMA_READ: begin
        dma_rd   = 1'b1;
        dma_addr = src + {8'h00, idx};
        state_nx = DMA_WRITE;
      end
      DMA_WRITE: begin
        dma_wr    = 1'b1;
        dma_addr  = OAM_BASE + {8'h00, idx};
        dma_wdata = mem_rdata;
        state_nx  = last ? DMA_IDLE : DMA_READ;
      end
      default: state_nx = DMA_IDLE;
    endcase
    // A new FF46 write always (re)starts, abandoning any byte in flight.
    if (start) state_nx = DMA_START;
  end

endmodule

// File: rtl/vram_oam_arbiter.sv
// Shared memory port arbiter: DMA > PPU > CPU, PPU-mode VRAM/OAM locking, OAM DMA.
// Ports: cpu_* bus, ppu_* fetch, mem_* port, dma_active. VRAM_LOCK_EN enables mode locking.
module vram_oam_arbiter
  import gb_pkg::*;
#(
  parameter int DMA_LEN = DMA_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [1:0]  ppu_mode,
  input  logic        lcd_on,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

  logic        ff46_wr;
  logic        cpu_io;
  logic        cpu_lock;
  logic        cpu_ok;
  logic        cpu_gnt_rd;
  logic        cpu_gnt_wr;
  logic        ppu_gnt;
  logic        dma_port;
  logic        dma_rd;
  logic        dma_wr;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;

  logic        cpu_pend, cpu_pend_ok;
  logic        ppu_pend, ppu_pend_ok;
  logic [7:0]  cpu_hold, ppu_hold;

  assign ff46_wr = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign cpu_io  = (cpu_addr >= IO_BASE);

  oam_dma_engine #(
    .DMA_LEN (DMA_LEN)
  ) u_dma (
    .clk        (clk),
    .rst        (rst),
    .start      (ff46_wr),
    .start_page (cpu_wdata),
    .mem_rdata  (mem_rdata),
    .dma_rd     (dma_rd),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .active     (dma_active)
  );

`ifdef VRAM_LOCK_EN
  logic is_vram, is_oam, m_draw, m_scan;
  assign is_vram  = in_rng(cpu_addr, VRAM_BASE, VRAM_END);
  assign is_oam   = in_rng(cpu_addr, OAM_BASE, OAM_END);
  assign m_draw   = (ppu_mode == 2'(DRAW));
  assign m_scan   = (ppu_mode == 2'(SCAN));
  assign cpu_lock = lcd_on &&
                    ((is_vram && m_draw) ||
                     (is_oam && (m_draw || m_scan)));
`else
  logic unused_lock;
  assign unused_lock = ^{ppu_mode, lcd_on};
  assign cpu_lock    = 1'b0;
`endif

  // START does not touch the port, so the PPU may still fetch then.
  assign dma_port   = (dma_rd || dma_wr) && !rst;
  assign ppu_gnt    = ppu_rd && !dma_port && !rst;
  assign cpu_ok     = !dma_active && !ppu_rd && !cpu_lock &&
                      !cpu_io && !rst;
  assign cpu_gnt_rd = cpu_rd && cpu_ok;
  assign cpu_gnt_wr = cpu_wr && cpu_ok;

  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    unique case (1'b1)
      dma_port: begin
        mem_addr  = dma_addr;
        mem_rd    = dma_rd;
        mem_wr    = dma_wr;
        mem_wdata = dma_wdata;
      end
      ppu_gnt: begin
        mem_addr = ppu_addr;
        mem_rd   = 1'b1;
      end
      cpu_gnt_rd: begin
        mem_addr = cpu_addr;
        mem_rd   = 1'b1;
      end
      cpu_gnt_wr: begin
        mem_addr  = cpu_addr;
        mem_wr    = 1'b1;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  // Port data arrives the cycle after the strobe; show it then and
  // latch it so it holds until the same requester reads again.
  assign cpu_rdata = !cpu_pend   ? cpu_hold :
                     cpu_pend_ok ? mem_rdata : 8'hFF;
  assign ppu_rdata = !ppu_pend   ? ppu_hold :
                     ppu_pend_ok ? mem_rdata : 8'hFF;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_pend    <= 1'b0;
      cpu_pend_ok <= 1'b0;
      cpu_hold    <= 8'hFF;
      ppu_pend    <= 1'b0;
      ppu_pend_ok <= 1'b0;
      ppu_hold    <= 8'hFF;
    end else begin
      if (cpu_pend) cpu_hold <= cpu_rdata;
      if (ppu_pend) ppu_hold <= ppu_rdata;
      cpu_pend    <= cpu_rd;
      cpu_pend_ok <= cpu_gnt_rd;
      ppu_pend    <= ppu_rd;
      ppu_pend_ok <= ppu_gnt;
    end
  end

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// Scoreboard bench for vram_oam_arbiter: expected port/read traffic queued by stimulus,
// popped and compared by a negedge monitor.
module tb_vram_oam_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic [1:0]  ppu_mode = 2'd0;
  logic        lcd_on = 1'b1;
  logic        ppu_rd = 1'b0;
  logic [15:0] ppu_addr = '0;
  logic [7:0]  ppu_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        dma_active;

  int errors = 0;
  int checks = 0;

  logic [15:0] rd_q[$];
  logic [23:0] wr_q[$];
  logic [7:0]  cpu_q[$];
  logic [7:0]  ppu_q[$];

  always #5 clk = ~clk;

  vram_oam_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .ppu_mode   (ppu_mode),
    .lcd_on     (lcd_on),
    .ppu_rd     (ppu_rd),
    .ppu_addr   (ppu_addr),
    .ppu_rdata  (ppu_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dma_active (dma_active)
  );

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void unexpected(input string nm,
                                     input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected none", nm, act);
  endfunction

  // Synchronous memory model: data for the strobed address next cycle.
  always @(posedge clk)
    if (mem_rd) mem_rdata <= f(mem_addr);

  logic cpu_pend = 1'b0;
  logic ppu_pend = 1'b0;

  always @(negedge clk) begin
    if (mem_rd) begin
      if (rd_q.size() == 0) unexpected("port_rd", {16'h0, mem_addr});
      else chk("port_rd_addr", {16'h0, mem_addr}, {16'h0, rd_q.pop_front()});
    end
    if (mem_wr) begin
      if (wr_q.size() == 0)
        unexpected("port_wr", {8'h0, mem_addr, mem_wdata});
      else
        chk("port_wr", {8'h0, mem_addr, mem_wdata}, {8'h0, wr_q.pop_front()});
    end
    if (cpu_pend) begin
      if (cpu_q.size() == 0) unexpected("cpu_rdata", {24'h0, cpu_rdata});
      else chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, cpu_q.pop_front()});
    end
    if (ppu_pend) begin
      if (ppu_q.size() == 0) unexpected("ppu_rdata", {24'h0, ppu_rdata});
      else chk("ppu_rdata", {24'h0, ppu_rdata}, {24'h0, ppu_q.pop_front()});
    end
    cpu_pend <= cpu_rd && !rst;
    ppu_pend <= ppu_rd && !rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dma(input logic [15:0] src,
                          input int nrd,
                          input int nwr);
    for (int i = 0; i < nrd; i++) rd_q.push_back(src + 16'(i));
    for (int i = 0; i < nwr; i++)
      wr_q.push_back({16'hFE00 + 16'(i), f(src + 16'(i))});
  endtask

  task automatic wr_ff46(input logic [7:0] v);
    cpu_addr  = 16'hFF46;
    cpu_wdata = v;
    cpu_wr    = 1'b1;
    step();
    cpu_wr    = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cpu_rdata"}, {24'h0, cpu_rdata}, 32'hFF);
    chk({tag, "_ppu_rdata"}, {24'h0, ppu_rdata}, 32'hFF);
    chk({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
    chk({tag, "_mem_rd"}, {31'h0, mem_rd}, 32'h0);
    chk({tag, "_mem_wr"}, {31'h0, mem_wr}, 32'h0);
    chk({tag, "_mem_wdata"}, {24'h0, mem_wdata}, 32'h0);
    chk({tag, "_dma_active"}, {31'h0, dma_active}, 32'h0);
  endtask

  initial begin
    repeat (3) step();
    chk_idle("reset");
    rst = 1'b0;
    step();

    // VRAM read in DRAW, then in H_BLANK.
    ppu_mode = 2'd3;
    cpu_addr = 16'h8100;
    cpu_rd   = 1'b1;
`ifdef VRAM_LOCK_EN
    cpu_q.push_back(8'hFF);
`else
    rd_q.push_back(16'h8100);
    cpu_q.push_back(f(16'h8100));
`endif
    step();
    cpu_rd = 1'b0;
    step();
    ppu_mode = 2'd0;
    cpu_rd   = 1'b1;
    rd_q.push_back(16'h8100);
    cpu_q.push_back(f(16'h8100));
    step();
    cpu_rd = 1'b0;
    step();

    // OAM write in SCAN, then in V_BLANK.
    ppu_mode  = 2'd2;
    cpu_addr  = 16'hFE10;
    cpu_wdata = 8'h33;
    cpu_wr    = 1'b1;
`ifndef VRAM_LOCK_EN
    wr_q.push_back({16'hFE10, 8'h33});
`endif
    step();
    ppu_mode = 2'd1;
    wr_q.push_back({16'hFE10, 8'h33});
    step();
    cpu_wr = 1'b0;

    // VRAM write in DRAW.
    ppu_mode  = 2'd3;
    cpu_addr  = 16'h8000;
    cpu_wdata = 8'h5A;
    cpu_wr    = 1'b1;
`ifndef VRAM_LOCK_EN
    wr_q.push_back({16'h8000, 8'h5A});
`endif
    step();
    cpu_wr   = 1'b0;
    ppu_mode = 2'd0;
    step();

    // PPU and CPU contend for 9800: PPU wins, CPU sees FF.
    cpu_addr = 16'h9800;
    ppu_addr = 16'h9800;
    cpu_rd   = 1'b1;
    ppu_rd   = 1'b1;
    rd_q.push_back(16'h9800);
    ppu_q.push_back(f(16'h9800));
    cpu_q.push_back(8'hFF);
    step();
    cpu_rd = 1'b0;
    ppu_rd = 1'b0;
    step();

    // Full DMA from C100.
    push_dma(16'hC100, 160, 160);
    wr_ff46(8'hC1);
    chk("dma1_start_active", {31'h0, dma_active}, 32'h1);
    step();
    chk("dma1_first_rd", {15'h0, mem_rd, mem_addr}, {15'h0, 1'b1, 16'hC100});
    repeat (319) step();
    chk("dma1_last_active", {31'h0, dma_active}, 32'h1);
    chk("dma1_last_wr", {15'h0, mem_wr, mem_addr}, {15'h0, 1'b1, 16'hFE9F});
    step();
    chk("dma1_done", {31'h0, dma_active}, 32'h0);
    step();

    // Restart: C1 then D0 fifty cycles later.
    push_dma(16'hC100, 25, 24);
    push_dma(16'hD000, 160, 160);
    wr_ff46(8'hC1);
    repeat (49) step();
    wr_ff46(8'hD0);
    chk("dma2_restart_active", {31'h0, dma_active}, 32'h1);
    repeat (320) step();
    chk("dma2_last_active", {31'h0, dma_active}, 32'h1);
    step();
    chk("dma2_done", {31'h0, dma_active}, 32'h0);
    step();

    // FF46 write alongside a PPU fetch, then PPU/CPU reads during DMA.
    rd_q.push_back(16'h9000);
    ppu_q.push_back(f(16'h9000));
    push_dma(16'hC200, 160, 160);
    ppu_addr = 16'h9000;
    ppu_rd   = 1'b1;
    wr_ff46(8'hC2);
    ppu_rd = 1'b0;
    chk("dma3_start_active", {31'h0, dma_active}, 32'h1);
    step();
    ppu_addr = 16'h9800;
    ppu_rd   = 1'b1;
    cpu_addr = 16'h8000;
    cpu_rd   = 1'b1;
    ppu_q.push_back(8'hFF);
    cpu_q.push_back(8'hFF);
    step();
    ppu_rd = 1'b0;
    cpu_rd = 1'b0;
    repeat (318) step();
    chk("dma3_last_active", {31'h0, dma_active}, 32'h1);
    step();
    chk("dma3_done", {31'h0, dma_active}, 32'h0);
    step();

    // Reset in the middle of a DMA.
    push_dma(16'hC300, 49, 49);
    wr_ff46(8'hC3);
    repeat (99) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_no_rd", {31'h0, mem_rd}, 32'h0);
    chk("rst_mid_no_wr", {31'h0, mem_wr}, 32'h0);
    step();
    rst = 1'b0;
    chk_idle("rst_mid");
    repeat (20) step();
    chk("rst_stays_idle", {31'h0, dma_active}, 32'h0);

    repeat (3) step();
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("ppu_q_drained", ppu_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vram_oam_arbiter.md
# vram_oam_arbiter

Owns the single memory port shared by the CPU, the PPU fetch engine and the OAM DMA engine. It grants the port each cycle by fixed priority, applies PPU-mode access blocking to VRAM and OAM, and runs the FF46-triggered 160-byte OAM DMA transfer. It sits between the CPU bus decoder, the PPU and the system memory decoder.

## Interface

- DMA_LEN, 160, bytes copied per DMA transfer.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_addr  in  16  CPU address.
- cpu_rd  in  1  CPU read strobe, 1 cycle.
- cpu_wr  in  1  CPU write strobe, 1 cycle.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data, registered.
- ppu_mode  in  2  PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
- lcd_on  in  1  LCDC bit 7.
- ppu_rd  in  1  PPU fetch request.
- ppu_addr  in  16  PPU fetch address.
- ppu_rdata  out  8  PPU fetch data.
- mem_addr  out  16  port address.
- mem_rd  out  1  port read strobe.
- mem_wr  out  1  port write strobe.
- mem_wdata  out  8  port write data.
- mem_rdata  in  8  port read data, valid the cycle after mem_rd.
- dma_active  out  1  DMA transfer in progress.

## Operation

- Regions: VRAM 8000–9FFF, OAM FE00–FE9F. CPU addresses FF00–FFFF are never forwarded to the port; the only one acted on is a write to FF46.
- Grant priority per cycle: DMA > PPU > CPU. Loser's access is dropped, never queued.
- CPU blocking (lcd_on=1 only): VRAM blocked in mode 3; OAM blocked in modes 2 and 3. Any CPU access except an FF46 write is blocked while dma_active=1.
- Blocked or dropped CPU read returns cpu_rdata=FF; blocked write produces no mem_wr.
- PPU read not granted (DMA owns port) returns ppu_rdata=FF.
- DMA states: DMA_IDLE, DMA_START, DMA_READ, DMA_WRITE.
  - IDLE -> START on CPU write to FF46; latch src = {cpu_wdata, 8'h00}, idx=0.
  - START -> READ after 1 cycle.
  - READ: mem_rd, mem_addr = src + idx -> WRITE.
  - WRITE: mem_wr, mem_addr = FE00 + idx, mem_wdata = mem_rdata; idx==DMA_LEN-1 -> IDLE, else idx+1 -> READ.
- FF46 write during DMA: restart in START with new src, idx=0; the in-flight byte is abandoned.
- idx is 8 bits; src+idx computed in 16 bits, no wrap past the low byte at DMA_LEN=160.

## Timing

- Reset values: cpu_rdata=FF, ppu_rdata=FF, mem_addr=0, mem_rd=0, mem_wr=0, mem_wdata=0, dma_active=0; DMA state IDLE, idx=0.
- mem_* outputs are combinational from the current grant and DMA state.
- CPU/PPU read: strobe at cycle N, data on cpu_rdata/ppu_rdata from cycle N+1, held until the next read from the same requester.
- DMA: FF46 write sampled at edge T; dma_active=1 from T+1 (START); byte i read at T+2+2i, written at T+3+2i; last write T+321; dma_active=0 from T+322.
- rst during DMA aborts immediately; no further mem_wr.
- Simultaneous cpu_wr to FF46 and ppu_rd in the same cycle: PPU is granted the port; DMA starts next cycle.

## Configuration

- VRAM_LOCK_EN defined: mode-based CPU blocking of VRAM/OAM as above.
- VRAM_LOCK_EN undefined: CPU may access VRAM/OAM in any mode when it wins arbitration; DMA blocking and priority unchanged (bring-up/debug).

## Structure

- Shared package gb_pkg: PPU mode enum (H_BLANK, V_BLANK, SCAN, DRAW), DMA state enum, constants VRAM_BASE, VRAM_END, OAM_BASE, OAM_END, DMA_REG_ADDR (FF46).
- One sub-module: oam_dma_engine (state machine, src/idx, strobes). Arbitration and blocking logic stays in the top.

## Test plan

- lcd_on=1, mode 3, CPU read 8100 -> no mem_rd, cpu_rdata=FF next cycle; mode 0 repeat -> mem_rd, cpu_rdata=mem_rdata.
- CPU write FF46=C1 at T -> dma_active T+1..T+321; writes FE00..FE9F receive data read from C100..C19F; first mem_rd at T+2.
- FF46=C1, then FF46=D0 at T+50 -> restart, 160 writes sourced D000..D09F, dma_active clears 322 cycles after second write.
- ppu_rd=1 at 9800 during DMA -> ppu_rdata=FF; same cycle as CPU read 9800 with no DMA -> PPU granted, CPU gets FF.
- rst asserted at T+100 of a DMA -> dma_active=0, no mem_wr afterwards, all outputs at reset values.
- VRAM_LOCK_EN undefined, mode 3, CPU write 8000=5A -> mem_wr with mem_wdata=5A.
